// File: rtl/relu_pkg.sv
// rtl/relu_pkg.sv - shared single-precision float helpers for the ReLU layers
package relu_pkg;

    // IEEE-754 single-precision layout, MSB first.
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } float_t;

    localparam logic [7:0]  FP_EXP_MAX  = 8'd255;
    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

    // Strictly positive and not NaN: +0.0, -0.0, negatives and NaN all report 0.
    // +Inf and positive denormals count as positive.
    function automatic logic fp_is_pos(input float_t f);
        logic is_nan;
        logic is_zero;
        is_nan  = (f.exp == FP_EXP_MAX) && (f.man != 23'd0);
        is_zero = ({f.exp, f.man} == 31'd0);
        return !f.sign && !is_zero && !is_nan;
    endfunction

endpackage

// File: rtl/relu_bwd_lane.sv
// rtl/relu_bwd_lane.sv - combinational per-lane ReLU gradient gate and power-of-two scale
module relu_bwd_lane
    import relu_pkg::*;
#(
    parameter int NEG_SLOPE_EN   = 0,
    parameter int NEG_SLOPE_LOG2 = -3
)(
    input  logic        pos,
    input  logic        sign,
    input  logic [7:0]  exp,
    input  logic [22:0] man,
    output logic [31:0] result
);

    // Scaling by 2^k only moves the exponent; the 10-bit signed width holds
    // exp (0..255) plus a shift down to -126 without wrapping.
    localparam logic signed [9:0] SLOPE_SHIFT = 10'(NEG_SLOPE_LOG2);

    logic signed [9:0] exp_scaled;

    // Pass the gradient on the positive path; otherwise zero it or scale it.
    always_comb begin
        exp_scaled = $signed({2'b00, exp}) + SLOPE_SHIFT;
        result     = FP_POS_ZERO;
        if (pos) begin
            result = {sign, exp, man};
        end else if (NEG_SLOPE_EN == 0) begin
            result = FP_POS_ZERO;
        end else if (exp == FP_EXP_MAX) begin
            // Inf and NaN survive a finite scale unchanged.
            result = {sign, exp, man};
        end else if (exp == 8'd0) begin
            // Denormal or zero gradient: flush, keeping the sign.
            result = {sign, 31'd0};
        end else if (exp_scaled <= 10'sd0) begin
            // Scaled value would be denormal: flush, keeping the sign.
            result = {sign, 31'd0};
        end else begin
            result = {sign, exp_scaled[7:0], man};
        end
    end

endmodule

// File: rtl/relu_backward.sv
// rtl/relu_backward.sv - two-stage streaming ReLU backward pass with per-blob beat counter
module relu_backward
    import relu_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int NEG_SLOPE_EN   = 0,
    parameter int NEG_SLOPE_LOG2 = -3,
    parameter int CNT_W          = 16
)(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [32*WIDTH-1:0]  top_diff,
    input  logic [32*WIDTH-1:0]  bottom_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [32*WIDTH-1:0]  out_diff,
    output logic [CNT_W-1:0]     beat_count
);

    if (NEG_SLOPE_LOG2 > 0 || NEG_SLOPE_LOG2 < -126) begin : g_bad_slope
        $error("relu_backward: NEG_SLOPE_LOG2=%0d outside -126..0", NEG_SLOPE_LOG2);
    end

    logic adv1;
    logic adv2;
    logic accept;

    float_t top_f [WIDTH];

    logic                    s1_valid;
    logic                    s1_last;
    logic [WIDTH-1:0]        s1_pos;
    logic [WIDTH-1:0]        s1_sign;
    logic [WIDTH-1:0][7:0]   s1_exp;
    logic [WIDTH-1:0][22:0]  s1_man;

    logic [32*WIDTH-1:0]     lane_diff;

    logic                    s2_valid;
    logic                    s2_last;
    logic [32*WIDTH-1:0]     s2_diff;

    logic [CNT_W-1:0]        count;

    // A stage may load when it is empty or its contents move on this edge;
    // in_ready depends only on pipeline state and out_ready, never on in_valid.
    always_comb begin
        adv2   = !s2_valid || out_ready;
        adv1   = !s1_valid || adv2;
        accept = in_valid && adv1;
    end

    assign in_ready = adv1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        assign top_f[i] = top_diff[32*i +: 32];

        relu_bwd_lane #(
            .NEG_SLOPE_EN   (NEG_SLOPE_EN),
            .NEG_SLOPE_LOG2 (NEG_SLOPE_LOG2)
        ) u_lane (
            .pos    (s1_pos[i]),
            .sign   (s1_sign[i]),
            .exp    (s1_exp[i]),
            .man    (s1_man[i]),
            .result (lane_diff[32*i +: 32])
        );
    end

    // Stage 1: classify bottom_data and split top_diff into fields.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_pos   <= '0;
            s1_sign  <= '0;
            s1_exp   <= '0;
            s1_man   <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_last <= in_last;
                for (int i = 0; i < WIDTH; i++) begin
                    s1_pos[i]  <= fp_is_pos(bottom_data[32*i +: 32]);
                    s1_sign[i] <= top_f[i].sign;
                    s1_exp[i]  <= top_f[i].exp;
                    s1_man[i]  <= top_f[i].man;
                end
            end
        end
    end

    // Stage 2: register the lane results; held unchanged while stalled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_diff  <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_last <= s1_last;
                s2_diff <= lane_diff;
            end
        end
    end

    // Beats accepted in the current blob; the closing beat returns it to 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (accept) begin
            count <= in_last ? '0 : count + 1'b1;
        end
    end

    assign out_valid  = s2_valid;
    assign out_last   = s2_last;
    assign out_diff   = s2_diff;
    assign beat_count = count;

endmodule

// File: doc/relu_backward.md
Name: relu_backward

Overview:
- Backward-propagation counterpart of the ReLU forward activation layer. Streams WIDTH-lane IEEE-754 single-precision vectors.
- For each lane, computes the gradient `bottom_diff = (bottom_data > 0) ? top_diff : top_diff * negative_slope`.
- Sits between the upstream layer's gradient stream and the downstream backward layer.
- Uses a 2-stage valid/ready pipeline with full throughput and a per-blob beat counter.

Parameters:
- WIDTH, 4: number of 32-bit float lanes per beat.
- NEG_SLOPE_EN, 0: 0 means the slope is 0 and the non-positive path outputs +0.0. 1 means the slope is 2^NEG_SLOPE_LOG2.
- NEG_SLOPE_LOG2, -3: signed integer in the range -126..0. Used only when NEG_SLOPE_EN=1.
- CNT_W, 16: width of the beat counter.

Ports:
- clk, in, 1: clock.
- reset_n, in, 1: synchronous active-low reset.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: block accepts the input beat.
- in_last, in, 1: final beat of the blob.
- top_diff, in, 32 x WIDTH: upstream gradient vector.
- bottom_data, in, 32 x WIDTH: forward-pass input vector, aligned with top_diff.
- out_valid, out, 1: output beat valid.
- out_ready, in, 1: downstream accepts the beat.
- out_last, out, 1: in_last delayed through the pipeline.
- out_diff, out, 32 x WIDTH: bottom_diff vector.
- beat_count, out, CNT_W: beats accepted in the current blob.

Behaviour:
- Reset (synchronous, clk edge with reset_n=0):
  - s1_valid=0, s2_valid=0, out_valid=0, out_last=0, out_diff=all 0, beat_count=0.
  - Any in-flight beats are discarded. in_ready reflects the empty pipeline on the first cycle after reset.
- Handshake:
  - A transfer occurs when valid & ready on the same edge.
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1 (combinational). in_ready must not depend on in_valid.
  - Once out_valid=1, out_diff and out_last hold stable until out_ready=1.
- Latency and throughput:
  - 2 cycles from input accept to out_valid.
  - One beat per cycle sustained while out_ready=1.
  - A 2-deep bubble-free stall is absorbed without loss or duplication.
- Stage 1 registers, per lane:
  - pos flag, exponent, sign, mantissa, and in_last.
  - pos = sign==0 and bits[30:0]!=0 and not NaN, where NaN is exp==255 with mantissa!=0.
  - +0.0, -0.0, negatives and NaN all take the non-positive path.
- Stage 2 result, per lane:
  - If pos, out = top_diff unchanged.
  - Else if NEG_SLOPE_EN=0, out = 32'h0000_0000.
  - Else if top exp==255, pass unchanged (Inf/NaN preserved).
  - Else if top exp==0, out = {sign, 31'b0}. Denormals flush to zero.
  - Else e = exp + NEG_SLOPE_LOG2, computed in a signed 10-bit intermediate.
  - If e<=0, out = {sign, 31'b0} (underflow flush). Otherwise out = {sign, e[7:0], mantissa}.
  - The sign is always preserved on the scaled path.
- beat_count:
  - Increments on each input accept.
  - Resets to 0 on an accept with in_last=1.
  - Wraps at 2^CNT_W-1 → 0 without error.
- Simultaneous events:
  - A stage 2 drain and a stage 1 refill in the same cycle are legal.
  - Accept, advance and output on one edge keeps the pipeline full.
- Elaboration check: an out-of-range NEG_SLOPE_LOG2 (>0 or <-126) triggers a $error.

Decomposition:
- Package relu_pkg holds:
  - float_t, a packed struct {sign, exp[7:0], man[22:0]}.
  - Constants FP_EXP_MAX=255, FP_POS_ZERO=32'h0.
  - Function fp_is_pos(). Shared with relu_forward.
- One sub-module, relu_bwd_lane: purely combinational per-lane gate and scale. Instantiated WIDTH times in a generate loop.
- The pipeline registers, handshake and counter live in the top module.

Test Plan:
1. Slope 0 (NEG_SLOPE_EN=0), out_ready=1:
   - bottom={3F800000, BF800000, 00000000, 80000000}, top all 40000000.
   - Expect out_diff={40000000, 0, 0, 0} two cycles after accept.
2. NEG_SLOPE_EN=1, LOG2=-3:
   - bottom=BF800000, top=40000000 → 3E800000.
   - top=C0000000 → BE800000.
   - top=7F800000 → 7F800000.
   - top=01000000 → 00000000 (underflow).
   - bottom=7FC00000 (NaN) with top=40000000 → 3E800000.
3. Backpressure:
   - Send 8 beats with incrementing top values while out_ready toggles 1,0,0,1,...
   - Expect all 8 delivered in order, each exactly once, and data stable during stalls.
   - in_ready=0 only when both stages are full and out_ready=0.
4. Blob framing:
   - 5 beats with in_last on beat 5.
   - Expect beat_count 1,2,3,4,0 after each accept, and out_last only on output beat 5.
5. Reset mid-stream:
   - Assert reset_n=0 for one cycle while both stages are valid.
   - Expect out_valid=0, beat_count=0 next cycle and no stale beat afterward. The next beat arrives with latency 2.
6. Counter wrap, CNT_W=4:
   - 17 beats without in_last.
   - Expect beat_count 15 → 0 → 1.
